// File: rtl/z80_io_initiator_pkg.sv
// Shared Z80 bus definitions: bus-cycle states, direction encoding and
// default timing constants. Also used by the cpm_io responder benches.
package z80_bus_pkg;

  // Z80 I/O cycle phases. TWA is the automatic I/O wait state, TW the
  // WAIT-stretched state.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TWA  = 3'd3,
    TW   = 3'd4,
    T3   = 3'd5
  } z80_state_e;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int         DEF_TIMEOUT_CYCLES = 1023;
  localparam logic [7:0] FLOAT_BUS          = 8'hFF;

  // Strobes are high only in the phases where IORQ is asserted.
  function automatic logic is_strobe_state(z80_state_e s);
    return (s == T2) || (s == TWA) || (s == TW);
  endfunction

endpackage

// File: rtl/z80_io_initiator_if.sv
// Request/response port plus Z80 I/O strobe bus of the initiator.
// master = initiator side, slave = requester/responder side.
interface z80_io_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       io_rd;
  logic       io_wr;
  logic [7:0] io_adr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, io_rdata, io_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           io_rd, io_wr, io_adr, io_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, io_rdata, io_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           io_rd, io_wr, io_adr, io_wdata
  );
endinterface

// File: rtl/z80_io_initiator_wait_timer.sv
// Saturating wait-state counter with clear/enable and a terminal flag.
// term is high when the next enabled count reaches LIMIT, so the caller
// can abort on the same edge the LIMIT-th wait cycle ends.
module z80_wait_timer #(
  parameter int W     = 10,
  parameter int LIMIT = 1023
) (
  input  logic         clk_4,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);

  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  // Clear wins over enable; the count holds at LIMIT instead of wrapping.
  always_ff @(posedge clk_4) begin
    if (!reset || clr)
      count <= '0;
    else if (en && (count != LIM))
      count <= count + W'(1);
  end

  assign term = (count >= LIM_M1);

endmodule

// File: rtl/z80_io_initiator.sv
// Z80 I/O bus-cycle initiator: turns single-byte valid/ready requests into
// IN/OUT cycles (T1, T2, automatic wait, WAIT-stretched TW, T3) with a
// timeout on a responder that never releases WAIT.
module z80_io_initiator
  import z80_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int         WAIT_W         = 10,
  parameter logic [7:0] TIMEOUT_RDATA  = FLOAT_BUS
) (
  input  logic              clk_4,
  input  logic              reset,
  z80_io_if.master          bus,
  output logic              busy,
  output logic [WAIT_W-1:0] wait_count
);

  z80_state_e        state, state_nxt;
  logic              dir_q;
  logic              ready_q;
  logic              tmo_q;
  logic [7:0]        adr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic [WAIT_W-1:0] tcount;
  logic              tterm;
  logic              accept;
  logic              tw_ok;
  logic              tw_tmo;
  logic              strobe;
  logic              timer_clr;
  logic              timer_en;

  assign accept    = bus.req_valid && ready_q && (state == IDLE);
  assign tw_ok     = (state == TW) && bus.io_ready;
  assign tw_tmo    = (state == TW) && !bus.io_ready && tterm;
  assign strobe    = is_strobe_state(state);
  assign timer_clr = (state == TWA);
  assign timer_en  = (state == TW) && !bus.io_ready;

  z80_wait_timer #(
    .W     (WAIT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_4 (clk_4),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .count (tcount),
    .term  (tterm)
  );

  // State register; reset drops any cycle in flight without a response.
  always_ff @(posedge clk_4) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus-cycle sequencing; io_ready is only looked at in TW.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = T1;
      T1:      state_nxt = T2;
      T2:      state_nxt = TWA;
      TWA:     state_nxt = TW;
      TW:      if (tw_ok || tw_tmo) state_nxt = T3;
      T3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered ready: held low through reset so nothing is accepted until
  // the cycle after release, then high exactly while the FSM is idle.
  always_ff @(posedge clk_4) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= (state_nxt == IDLE);
  end

  // Request latch and response capture.
  always_ff @(posedge clk_4) begin
    if (!reset) begin
      dir_q   <= DIR_IN;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      if (accept) begin
        adr_q   <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        dir_q   <= bus.req_write ? DIR_OUT : DIR_IN;
      end
      if (tw_ok) begin
        rdata_q <= (dir_q == DIR_IN) ? bus.io_rdata : 8'h00;
        wcnt_q  <= tcount;
      end
      if (tw_tmo) begin
        rdata_q <= (dir_q == DIR_IN) ? TIMEOUT_RDATA : 8'h00;
        tmo_q   <= 1'b1;
        wcnt_q  <= WAIT_W'(TIMEOUT_CYCLES);
      end
      // Timeout flag lives only for the T3 response cycle.
      if (state == T3) tmo_q <= 1'b0;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = (state == T3);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.io_rd       = strobe && (dir_q == DIR_IN);
  assign bus.io_wr       = strobe && (dir_q == DIR_OUT);
  assign bus.io_adr      = adr_q;
  assign bus.io_wdata    = wdata_q;
  assign busy            = (state != IDLE);
  assign wait_count      = wcnt_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
// Self-checking bench for z80_io_initiator: directed scenarios plus a
// randomized run against a cycle-count/memory reference model.
module tb_z80_io_initiator;

  localparam int TMO = 15;
  localparam int WW  = 10;

  logic          clk_4 = 1'b0;
  logic          reset = 1'b0;
  logic          busy;
  logic [WW-1:0] wait_count;

  z80_io_if bus ();

  z80_io_initiator #(
    .TIMEOUT_CYCLES (TMO),
    .WAIT_W         (WW),
    .TIMEOUT_RDATA  (8'hFF)
  ) dut (
    .clk_4      (clk_4),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .wait_count (wait_count)
  );

  always #5 clk_4 = ~clk_4;

  int         checks = 0;
  int         errors = 0;
  int         resp_wait = 0;
  logic [7:0] model_mem [256];

  function automatic logic [7:0] mem_init(int i);
    return 8'(i * 37) ^ 8'h5A;
  endfunction

  // Responder: releases WAIT resp_wait TW cycles late (0 = io_ready tied 1),
  // serves reads from its own memory and stores writes.
  logic [7:0] resp_mem [256];
  int         resp_cnt;
  initial begin
    for (int i = 0; i < 256; i++) resp_mem[i] = mem_init(i);
    resp_cnt     = 0;
    bus.io_ready = 1'b0;
    bus.io_rdata = 8'h00;
    forever begin
      @(negedge clk_4);
      if (bus.io_rd || bus.io_wr) resp_cnt++;
      else                        resp_cnt = 0;
      if (bus.io_wr) resp_mem[bus.io_adr] = bus.io_wdata;
      bus.io_ready = (resp_wait == 0) || (resp_cnt >= 3 + resp_wait);
      bus.io_rdata = bus.io_rd ? resp_mem[bus.io_adr] : 8'($urandom);
    end
  end

  // Issue one request and observe it; cycle 0 is the acceptance edge.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int nw, output int rsp_cyc, output int s_first,
                         output int s_last, output int bad_strobe, output int bad_adr,
                         output logic [7:0] rdata, output logic tmo,
                         output logic [WW-1:0] wc);
    int k;
    int guard;
    resp_wait     = nw;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk_4);
      guard++;
    end
    @(negedge clk_4);
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    rsp_cyc = -1; s_first = -1; s_last = -1; bad_strobe = 0; bad_adr = 0;
    rdata = 8'h00; tmo = 1'b0; wc = '0;
    k = 1;
    while (rsp_cyc < 0 && k < 2000) begin
      if (bus.io_rd || bus.io_wr) begin
        if (s_first < 0) s_first = k;
        s_last = k;
        if ((bus.io_rd && bus.io_wr) || (bus.io_rd && wr) || (bus.io_wr && !wr))
          bad_strobe++;
      end
      if (bus.io_adr !== a || bus.io_wdata !== d) bad_adr++;
      if (bus.rsp_valid === 1'b1) begin
        rsp_cyc = k;
        rdata   = bus.rsp_rdata;
        tmo     = bus.rsp_timeout;
        wc      = wait_count;
      end else begin
        @(negedge clk_4);
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr  = 8'h33; bus.req_wdata = 8'h77;
    repeat (3) begin
      @(negedge clk_4);
      checks++;
      if ({bus.io_rd, bus.io_wr, bus.req_ready, bus.rsp_valid, bus.rsp_timeout, busy} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl got %b want 000000",
                 {bus.io_rd, bus.io_wr, bus.req_ready, bus.rsp_valid, bus.rsp_timeout, busy});
      end
      checks++;
      if ({bus.io_adr, bus.io_wdata, bus.rsp_rdata} !== 24'h0 || wait_count !== '0) begin
        errors++;
        $display("FAIL reset_data got adr=%h wd=%h rd=%h wc=%0d want all 0",
                 bus.io_adr, bus.io_wdata, bus.rsp_rdata, wait_count);
      end
    end
    reset = 1'b1;
    @(negedge clk_4);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", bus.req_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy got %b want 0", busy);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_out_basic();
    int rc, sf, sl, bs, ba;
    logic [7:0] rd; logic to; logic [WW-1:0] wc;
    run_txn(1'b1, 8'h01, 8'h41, 0, rc, sf, sl, bs, ba, rd, to, wc);
    model_mem[8'h01] = 8'h41;
    checks++;
    if (rc !== 5 || sf !== 2 || sl !== 4) begin
      errors++; $display("FAIL out_timing got rsp=%0d strobe=%0d..%0d want 5 2..4", rc, sf, sl);
    end
    checks++;
    if (bs !== 0 || ba !== 0) begin
      errors++; $display("FAIL out_bus got badstrobe=%0d badadr=%0d want 0 0", bs, ba);
    end
    checks++;
    if (to !== 1'b0 || wc !== '0 || rd !== 8'h00) begin
      errors++; $display("FAIL out_rsp got tmo=%b wc=%0d rd=%h want 0 0 00", to, wc, rd);
    end
    @(negedge clk_4);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL out_idle got valid=%b ready=%b busy=%b want 0 1 0",
                         bus.rsp_valid, bus.req_ready, busy);
    end
  endtask

  task automatic test_in_wait();
    int rc, sf, sl, bs, ba;
    logic [7:0] rd; logic to; logic [WW-1:0] wc;
    run_txn(1'b0, 8'h00, 8'($urandom), 7, rc, sf, sl, bs, ba, rd, to, wc);
    checks++;
    if (rc !== 12 || sf !== 2 || sl !== 11) begin
      errors++; $display("FAIL in_wait_timing got rsp=%0d strobe=%0d..%0d want 12 2..11", rc, sf, sl);
    end
    checks++;
    if (rd !== 8'h5A || wc !== WW'(7) || to !== 1'b0 || bs !== 0 || ba !== 0) begin
      errors++; $display("FAIL in_wait_rsp got rd=%h wc=%0d tmo=%b bs=%0d ba=%0d want 5a 7 0 0 0",
                         rd, wc, to, bs, ba);
    end
    @(negedge clk_4);
  endtask

  task automatic test_timeout();
    int rc, sf, sl, bs, ba;
    logic [7:0] rd; logic to; logic [WW-1:0] wc;
    run_txn(1'b0, 8'h02, 8'($urandom), 1000, rc, sf, sl, bs, ba, rd, to, wc);
    checks++;
    if (rc !== 4 + TMO || sl !== 3 + TMO) begin
      errors++; $display("FAIL timeout_timing got rsp=%0d last_strobe=%0d want %0d %0d",
                         rc, sl, 4 + TMO, 3 + TMO);
    end
    checks++;
    if (to !== 1'b1 || rd !== 8'hFF) begin
      errors++; $display("FAIL timeout_rsp got tmo=%b rd=%h want 1 ff", to, rd);
    end
    @(negedge clk_4);
    checks++;
    if (bus.rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b want 0", bus.rsp_timeout);
    end
    run_txn(1'b0, 8'h02, 8'($urandom), 3, rc, sf, sl, bs, ba, rd, to, wc);
    checks++;
    if (rc !== 8 || to !== 1'b0 || rd !== model_mem[8'h02] || wc !== WW'(3)) begin
      errors++; $display("FAIL timeout_recover got rsp=%0d tmo=%b rd=%h wc=%0d want 8 0 %h 3",
                         rc, to, rd, wc, model_mem[8'h02]);
    end
    @(negedge clk_4);
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n = 0, cyc = 0, rd_seen = 0, overlap = 0, ready_busy = 0;
    logic just_acc;
    int rc, sf, sl, bs, ba;
    logic [7:0] rd; logic to; logic [WW-1:0] wc;
    logic [7:0] wd [3];
    for (int i = 0; i < 3; i++) wd[i] = 8'($urandom);
    resp_wait = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr  = 8'h10; bus.req_wdata = wd[0];
    while (cyc < 40) begin
      if (bus.io_rd) rd_seen++;
      if (bus.io_rd && bus.io_wr) overlap++;
      if (bus.req_ready && busy) ready_busy++;
      just_acc = 1'b0;
      if (bus.req_ready && bus.req_valid) begin
        acc[n] = cyc;
        model_mem[8'h10 + 8'(n)] = wd[n];
        n++;
        just_acc = 1'b1;
      end
      @(negedge clk_4);
      cyc++;
      if (just_acc) begin
        if (n < 3) begin
          bus.req_addr  = 8'h10 + 8'(n);
          bus.req_wdata = wd[n];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", n);
    end else begin
      checks++;
      if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
        errors++; $display("FAIL b2b_spacing got %0d %0d want 6 6", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (rd_seen !== 0 || overlap !== 0 || ready_busy !== 0) begin
      errors++; $display("FAIL b2b_strobes got rd=%0d overlap=%0d ready_busy=%0d want 0 0 0",
                         rd_seen, overlap, ready_busy);
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, 8'h10 + 8'(i), 8'($urandom), $urandom_range(0, 4), rc, sf, sl, bs, ba, rd, to, wc);
      checks++;
      if (rd !== model_mem[8'h10 + 8'(i)]) begin
        errors++; $display("FAIL b2b_readback%0d got %h want %h", i, rd, model_mem[8'h10 + 8'(i)]);
      end
      @(negedge clk_4);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0, stray = 0;
    int rc, sf, sl, bs, ba;
    logic [7:0] rd; logic to; logic [WW-1:0] wc;
    resp_wait = 30;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr  = 8'h20; bus.req_wdata = 8'($urandom);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk_4);
      guard++;
    end
    @(negedge clk_4);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk_4);
    checks++;
    if (bus.io_rd !== 1'b1) begin
      errors++; $display("FAIL midrst_in_tw got io_rd=%b want 1", bus.io_rd);
    end
    reset = 1'b0;
    @(negedge clk_4);
    checks++;
    if ({bus.io_rd, bus.io_wr, bus.rsp_valid, busy} !== 4'b0) begin
      errors++; $display("FAIL midrst_drop got %b want 0000",
                         {bus.io_rd, bus.io_wr, bus.rsp_valid, busy});
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk_4);
      if (bus.rsp_valid || bus.io_rd || bus.io_wr) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL midrst_stray got %0d want 0", stray);
    end
    run_txn(1'b0, 8'h20, 8'($urandom), 2, rc, sf, sl, bs, ba, rd, to, wc);
    checks++;
    if (rc !== 7 || rd !== model_mem[8'h20] || to !== 1'b0) begin
      errors++; $display("FAIL midrst_after got rsp=%0d rd=%h tmo=%b want 7 %h 0",
                         rc, rd, to, model_mem[8'h20]);
    end
    @(negedge clk_4);
  endtask

  task automatic test_random();
    int rc, sf, sl, bs, ba, nw, exp_rc;
    logic [7:0] rd, a, d, exp_rd; logic to, wr, exp_to; logic [WW-1:0] wc;
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom);
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      nw = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      exp_to = (nw >= TMO);
      exp_rc = exp_to ? 4 + TMO : 5 + nw;
      exp_rd = wr ? 8'h00 : (exp_to ? 8'hFF : model_mem[a]);
      run_txn(wr, a, d, nw, rc, sf, sl, bs, ba, rd, to, wc);
      if (wr) model_mem[a] = d;
      checks++;
      if (rc !== exp_rc || sf !== 2 || sl !== exp_rc - 1 || bs !== 0 || ba !== 0) begin
        errors++; $display("FAIL rand%0d_cycle got rsp=%0d s=%0d..%0d bs=%0d ba=%0d want rsp=%0d s=2..%0d",
                           t, rc, sf, sl, bs, ba, exp_rc, exp_rc - 1);
      end
      checks++;
      if (rd !== exp_rd || to !== exp_to || (!exp_to && wc !== WW'(nw))) begin
        errors++; $display("FAIL rand%0d_rsp got rd=%h tmo=%b wc=%0d want rd=%h tmo=%b wc=%0d",
                           t, rd, to, wc, exp_rd, exp_to, nw);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk_4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = mem_init(i);
    test_reset();
    test_out_basic();
    test_in_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
